// File: rtl/gate_seq_pkg.sv
// Shared state encoding and standard 2-input truth tables for the gate sequencer.
package gate_seq_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = IDLE,
      ST_SETTLE = SETTLE,
      ST_SAMPLE = SAMPLE,
      ST_FINISH = FINISH
   } state_e;

   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_XNOR2 = 4'b1001;

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// Stimulus/result bundle between the sequencer (slave) and the lab harness (master).
interface gate_seq_ctrl_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            gate_y;
   logic [N_IN-1:0] vec_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;

   modport master (
      output start, gate_y,
      input  vec_out, busy, done, pass, err_count
   );

   modport slave (
      input  start, gate_y,
      output vec_out, busy, done, pass, err_count
   );
endinterface

// File: rtl/gate_seq_timer.sv
// Per-vector settle counter: cleared on vector change, counts while settling,
// flags the last settle cycle.
module gate_seq_timer #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int               CNT_W   = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Exhaustive self-checking sequencer for one N_IN-input gate.
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN: end the run at the first mismatch.
module gate_seq_ctrl
   import gate_seq_pkg::*;
#(
   parameter int                    N_IN        = 2,
   parameter int                    HOLD_CYCLES = 4,
   parameter logic [2**N_IN-1:0]    TRUTH       = TT_AND2
) (
   input logic              clk,
   input logic              rst_n,
   gate_seq_ctrl_if.slave   bus
);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

   state_e          state_q;
   logic [N_IN-1:0] vec_q;
   logic [N_IN:0]   err_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            term_q;
   logic            tc_s;
   logic            mismatch_s;
   logic            stop_s;

   assign mismatch_s = (bus.gate_y != TRUTH[vec_q]);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
   assign stop_s = (vec_q == VEC_LAST) || mismatch_s;
`else
   assign stop_s = (vec_q == VEC_LAST);
`endif

   gate_seq_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (((state_q == ST_IDLE) && bus.start) || (state_q == ST_SAMPLE)),
      .en_i  (state_q == ST_SETTLE),
      .tc_o  (tc_s)
   );

   // Sequencer FSM with registered outputs. A terminating SAMPLE spends one
   // extra cycle (term_q) so FINISH computes pass from the settled err count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         term_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_SETTLE;
                  vec_q   <= '0;
                  err_q   <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  term_q  <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (tc_s) begin
                  state_q <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (term_q) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0);
               end else begin
                  if (mismatch_s) begin
                     err_q <= err_q + ERR_ONE;
                  end
                  if (stop_s) begin
                     term_q <= 1'b1;
                  end else begin
                     vec_q   <= vec_q + VEC_ONE;
                     state_q <= ST_SETTLE;
                  end
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               term_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.vec_out   = vec_q;
   assign bus.err_count = err_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;

endmodule
